// File: rtl/drive_input_conditioner.sv
// drive_input_conditioner: synchronises, debounces and arbitrates the four direction buttons
// and forces a motor dead time whenever a drive command is left.
module drive_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DEADTIME_CYCLES = 12500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rawUp,
   input  logic rawDown,
   input  logic rawLeft,
   input  logic rawRight,
   output logic btnUp,
   output logic btnDown,
   output logic btnLeft,
   output logic btnRight,
   output logic deadActive
);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DTW = $clog2(DEADTIME_CYCLES + 1);
   localparam logic [DBW-1:0] DB_TERM = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DTW-1:0] DT_TERM = DTW'(DEADTIME_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FWD, REV, LEFT, RIGHT, DEAD} state_t;

   logic [3:0] raw, s1, s2, stable;
   logic [DTW-1:0] dcnt;
   state_t state, nxt, req;

   assign raw = {rawRight, rawLeft, rawDown, rawUp};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end

   for (genvar i = 0; i < 4; i++) begin : g_db
      logic [DBW-1:0] cnt;
      logic st;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            cnt <= '0;
            st  <= 1'b0;
         end else if (s2[i] == st) begin
            cnt <= '0;
         end else if (cnt == DB_TERM) begin
            st  <= s2[i];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      assign stable[i] = st;
   end

   // Request is expressed as the drive state it selects; IDLE stands for "nothing pressed".
   assign req = stable[0] ? FWD : stable[1] ? REV : stable[2] ? LEFT : stable[3] ? RIGHT : IDLE;

   always_comb
      nxt = (state == IDLE) ? req
          : (state == DEAD) ? ((dcnt == DT_TERM) ? req : DEAD)
          : (req == state)  ? state : DEAD;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         dcnt       <= '0;
         btnUp      <= 1'b0;
         btnDown    <= 1'b0;
         btnLeft    <= 1'b0;
         btnRight   <= 1'b0;
         deadActive <= 1'b0;
      end else begin
         state      <= nxt;
         dcnt       <= (state == DEAD && nxt == DEAD) ? dcnt + 1'b1 : '0;
         btnUp      <= nxt == FWD;
         btnDown    <= nxt == REV;
         btnLeft    <= nxt == LEFT;
         btnRight   <= nxt == RIGHT;
         deadActive <= nxt == DEAD;
      end
endmodule
